// File: rtl/riscv_irq_ctrl.sv
// Machine-mode interrupt controller: mie/mip/mtvec/irq_edge CSRs, arbitration and trap req/ack FSM.
// Define RISCV_IRQ_PRIORITY_EN to add per-platform-source priority CSRs at 0x7C1/0x7C2.
module riscv_irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] TVEC_RESET  = 32'h0000_0004
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               timer_irq,
    input  logic               ext_irq,
    input  logic               mstatus_mie,
    input  logic [11:0]        csr_addr,
    input  logic               csr_we,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               trap_req,
    output logic [31:0]        trap_cause,
    output logic [31:0]        trap_target,
    input  logic               trap_ack,
    input  logic               mret,
    output logic               busy,
    output logic [1:0]         dbg_state_o
);
    localparam logic [11:0] ADDR_MIE   = 12'h304;
    localparam logic [11:0] ADDR_MTVEC = 12'h305;
    localparam logic [11:0] ADDR_MIP   = 12'h344;
    localparam logic [11:0] ADDR_EDGE  = 12'h7C0;
    localparam logic [11:0] ADDR_PRIO0 = 12'h7C1;
    localparam logic [11:0] ADDR_PRIO1 = 12'h7C2;
    localparam logic [31:0] PLAT_MASK  = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
    localparam logic [31:0] MIE_MASK   = PLAT_MASK | 32'h0000_0888;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;
    state_e state_q, state_d;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_s, prev_q, pend_q, pend_d, pend_clr, irq_edge_q;
    logic [31:0]        mie_q, mtvec_q, mip_val, elig, tgt, base;
    logic               msip_q, have;
    logic [4:0]         code;
    logic               req_q, req_d, busy_q, busy_d;
    logic [31:0]        cause_q, cause_d, target_q, target_d;

    assign irq_s       = sync_q[SYNC_STAGES-1];
    assign trap_req    = req_q;
    assign busy        = busy_q;
    assign trap_cause  = cause_q;
    assign trap_target = target_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= irq_s;
            pend_q <= pend_d;
        end
    end

    // Edge sources are sticky until accepted; a new rising edge beats the clear.
    always_comb begin
        pend_clr = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (state_q == REQ && trap_ack && cause_q[4:0] == 5'(16 + k)) pend_clr[k] = 1'b1;
        end
        pend_d = (irq_edge_q & ((pend_q & ~pend_clr) | (irq_s & ~prev_q)))
               | (~irq_edge_q & irq_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= '0;
            msip_q     <= 1'b0;
            irq_edge_q <= '0;
            mtvec_q    <= TVEC_RESET;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MIE:   mie_q      <= csr_wdata & MIE_MASK;
                ADDR_MIP:   msip_q     <= csr_wdata[3];
                ADDR_EDGE:  irq_edge_q <= csr_wdata[NUM_IRQ-1:0];
                ADDR_MTVEC: mtvec_q    <= {csr_wdata[31:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
                default: ;
            endcase
        end
    end

`ifdef RISCV_IRQ_PRIORITY_EN
    logic [2:0] prio_q [16];
    logic [2:0] best_prio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) prio_q[k] <= 3'd1;
        end else if (csr_we && csr_addr == ADDR_PRIO0) begin
            for (int k = 0; k < 8; k++) prio_q[k] <= csr_wdata[4*k +: 3];
        end else if (csr_we && csr_addr == ADDR_PRIO1) begin
            for (int k = 0; k < 8; k++) prio_q[k+8] <= csr_wdata[4*k +: 3];
        end
    end
`endif

    always_comb begin
        mip_val     = '0;
        mip_val[3]  = msip_q;
        mip_val[7]  = timer_irq;
        mip_val[11] = ext_irq;
        for (int k = 0; k < NUM_IRQ; k++) mip_val[16+k] = pend_q[k];
        elig = mip_val & mie_q & {32{mstatus_mie}};
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MIE:   csr_rdata = mie_q;
            ADDR_MIP:   csr_rdata = mip_val;
            ADDR_MTVEC: csr_rdata = mtvec_q;
            ADDR_EDGE:  csr_rdata[NUM_IRQ-1:0] = irq_edge_q;
`ifdef RISCV_IRQ_PRIORITY_EN
            ADDR_PRIO0: for (int k = 0; k < 8; k++) if (k < NUM_IRQ) csr_rdata[4*k +: 3] = prio_q[k];
            ADDR_PRIO1: for (int k = 0; k < 8; k++) if (k + 8 < NUM_IRQ) csr_rdata[4*k +: 3] = prio_q[k+8];
`endif
            default: ;
        endcase
    end

    // Fixed order MEI > MSI > MTI, then platform sources.
    always_comb begin
        have = 1'b1;
        code = 5'd0;
`ifdef RISCV_IRQ_PRIORITY_EN
        best_prio = 3'd0;
`endif
        if (elig[11])     code = 5'd11;
        else if (elig[3]) code = 5'd3;
        else if (elig[7]) code = 5'd7;
        else begin
            have = 1'b0;
`ifdef RISCV_IRQ_PRIORITY_EN
            for (int k = 0; k < NUM_IRQ; k++) begin
                if (elig[16+k] && prio_q[k] > best_prio) begin
                    best_prio = prio_q[k];
                    code      = 5'(16 + k);
                    have      = 1'b1;
                end
            end
`else
            for (int k = NUM_IRQ - 1; k >= 0; k--) begin
                if (elig[16+k]) begin
                    code = 5'(16 + k);
                    have = 1'b1;
                end
            end
`endif
        end
        base = {mtvec_q[31:2], 2'b00};
        tgt  = (mtvec_q[1:0] == 2'b01) ? base + {25'b0, code, 2'b00} : base;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        busy_d   = busy_q;
        cause_d  = cause_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                req_d  = 1'b0;
                if (have) begin
                    cause_d  = {1'b1, 26'b0, code};
                    target_d = tgt;
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: if (trap_ack) begin
                req_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = SERVICE;
            end
            SERVICE: if (mret) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl: expected traps queued at stimulus time, checked when trap_req rises.
module tb_riscv_irq_ctrl;
    localparam int NUM_IRQ = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic               timer_irq, ext_irq, mstatus_mie;
    logic [11:0]        csr_addr;
    logic               csr_we;
    logic [31:0]        csr_wdata, csr_rdata;
    logic               trap_req, trap_ack, mret, busy;
    logic [31:0]        trap_cause, trap_target;
    logic [1:0]         dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] rd;

    riscv_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2), .TVEC_RESET(32'h0000_0004)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .timer_irq(timer_irq), .ext_irq(ext_irq),
        .mstatus_mie(mstatus_mie), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_target(trap_target), .trap_ack(trap_ack), .mret(mret), .busy(busy),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_addr  = addr;
        csr_wdata = data;
        csr_we    = 1'b1;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
        csr_addr = addr;
        #1;
        data = csr_rdata;
    endtask

    task automatic push_trap(input logic [31:0] cause, input logic [31:0] target);
        exp_q.push_back({cause, target});
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (trap_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'b0, trap_req}, 32'h1);
    endtask

    task automatic pop_trap(input string tag);
        logic [63:0] e;
        e = exp_q.pop_front();
        check({tag, "_cause"}, trap_cause, e[63:32]);
        check({tag, "_target"}, trap_target, e[31:0]);
    endtask

    task automatic ack();
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; timer_irq = 1'b0; ext_irq = 1'b0; mstatus_mie = 1'b0;
        csr_addr = '0; csr_we = 1'b0; csr_wdata = '0; trap_ack = 1'b0; mret = 1'b0;
        tick(); tick();
        check("rst_req", {31'b0, trap_req}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        tick();
        csr_read(12'h305, rd); check("rst_mtvec", rd, 32'h0000_0004);
        csr_read(12'h304, rd); check("rst_mie", rd, 32'h0);
        csr_read(12'h344, rd); check("rst_mip", rd, 32'h0);

        // Edge source 2, vectored mode, exact latency
        mstatus_mie = 1'b1;
        csr_write(12'h7C0, 32'h0000_0004);
        csr_write(12'h304, 32'h0004_0000);
        csr_write(12'h305, 32'h0000_8001);
        csr_read(12'h305, rd); check("mtvec_rd", rd, 32'h0000_8001);
        csr_write(12'h305, 32'h0000_8003);
        csr_read(12'h305, rd); check("mtvec_warl", rd, 32'h0000_8000);
        csr_write(12'h305, 32'h0000_8001);
        push_trap(32'h8000_0012, 32'h0000_8048);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        tick();
        tick();
        check("edge_early", {31'b0, trap_req}, 32'h0);
        csr_read(12'h344, rd); check("edge_mip_set", rd, 32'h0004_0000);
        tick();
        check("edge_lat", {31'b0, trap_req}, 32'h1);
        pop_trap("edge");
        ack();
        check("edge_ack_req", {31'b0, trap_req}, 32'h0);
        check("edge_busy", {31'b0, busy}, 32'h1);
        csr_read(12'h344, rd); check("edge_mip_clr", rd, 32'h0);
        do_mret();
        check("edge_mret_busy", {31'b0, busy}, 32'h0);

        // MEI beats platform 0; one-cycle gap after mret
        csr_write(12'h7C0, 32'h0);
        csr_write(12'h304, 32'h0001_0800);
        push_trap(32'h8000_000B, 32'h0000_802C);
        push_trap(32'h8000_0010, 32'h0000_8040);
        ext_irq = 1'b1;
        irq_in[0] = 1'b1;
        wait_req("mei");
        pop_trap("mei");
        ack();
        ext_irq = 1'b0;
        tick();
        do_mret();
        check("gap_req", {31'b0, trap_req}, 32'h0);
        tick();
        check("plat0_req", {31'b0, trap_req}, 32'h1);
        pop_trap("plat0");
        ack();
        irq_in[0] = 1'b0;
        repeat (4) tick();
        do_mret();

        // Global enable gating of MTI, direct mode
        mstatus_mie = 1'b0;
        csr_write(12'h305, 32'h0000_2000);
        csr_write(12'h304, 32'h0000_0080);
        timer_irq = 1'b1;
        repeat (3) tick();
        check("mti_gated", {31'b0, trap_req}, 32'h0);
        push_trap(32'h8000_0007, 32'h0000_2000);
        mstatus_mie = 1'b1;
        tick();
        check("mti_req", {31'b0, trap_req}, 32'h1);
        pop_trap("mti");
        ack();
        timer_irq = 1'b0;
        do_mret();

        // Level source 1 drops mid-REQ: request stays committed
        csr_write(12'h304, 32'h0002_0000);
        push_trap(32'h8000_0011, 32'h0000_2000);
        irq_in[1] = 1'b1;
        wait_req("lvl1");
        irq_in[1] = 1'b0;
        csr_write(12'h304, 32'h0);
        csr_write(12'h305, 32'h0000_3001);
        repeat (4) tick();
        check("lvl1_hold_req", {31'b0, trap_req}, 32'h1);
        pop_trap("lvl1_hold");
        ack();
        check("lvl1_busy", {31'b0, busy}, 32'h1);
        do_mret();

        // Asynchronous reset mid-REQ
        csr_write(12'h305, 32'h0000_2000);
        csr_write(12'h304, 32'h0002_0000);
        push_trap(32'h8000_0011, 32'h0000_2000);
        irq_in[1] = 1'b1;
        wait_req("lvl1b");
        pop_trap("lvl1b");
        irq_in[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, trap_req}, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_cause", trap_cause, 32'h0);
        check("arst_target", trap_target, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        csr_read(12'h305, rd); check("arst_mtvec", rd, 32'h0000_0004);
        csr_read(12'h304, rd); check("arst_mie", rd, 32'h0);

`ifdef RISCV_IRQ_PRIORITY_EN
        csr_read(12'h7C1, rd); check("prio_rst", rd, 32'h1111_1111);
        csr_write(12'h7C1, 32'h1116_1151);
        csr_read(12'h7C1, rd); check("prio_rd", rd, 32'h1116_1151);
        csr_write(12'h304, 32'h0012_0000);
        push_trap(32'h8000_0014, 32'h0000_0004);
        push_trap(32'h8000_0011, 32'h0000_0004);
        irq_in[1] = 1'b1;
        irq_in[4] = 1'b1;
        wait_req("prio_hi");
        pop_trap("prio_hi");
        ack();
        csr_write(12'h7C1, 32'h1110_1151);
        do_mret();
        wait_req("prio_zero");
        pop_trap("prio_zero");
        ack();
        csr_read(12'h344, rd); check("prio_zero_mip", rd, 32'h0012_0000);
        irq_in = '0;
        repeat (4) tick();
        do_mret();
`else
        csr_write(12'h7C1, 32'h1234_5678);
        csr_read(12'h7C1, rd); check("prio_off_rd0", rd, 32'h0);
        csr_read(12'h7C2, rd); check("prio_off_rd1", rd, 32'h0);
`endif

        check("sb_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_irq_ctrl.md
Name: riscv_irq_ctrl

Overview:
- Parametrised machine-mode interrupt controller for the RV32 core.
- Merges the standard MSI/MTI/MEI sources with NUM_IRQ platform lines, which appear at mip[16+k].
- Owns mie, mip and mtvec, plus per-source edge/level configuration.
- Arbitrates the pending sources and presents one trap request at a time to the control unit over a req/ack handshake; tracks in-service state until mret.

Parameters:
- NUM_IRQ, 16: platform interrupt lines, legal 1..16, mapped to mip/mie bits 16..16+NUM_IRQ-1.
- SYNC_STAGES, 2: synchroniser flops on each irq_in line, legal 2..3.
- TVEC_RESET, 32'h0000_0004: reset value of mtvec.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous reset, active-low
- irq_in  in  NUM_IRQ  asynchronous platform interrupt lines
- timer_irq  in  1  level MTI source (already synchronous)
- ext_irq  in  1  level MEI source (already synchronous)
- mstatus_mie  in  1  global machine interrupt enable
- csr_addr  in  12  CSR address
- csr_we  in  1  CSR write strobe
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  combinational read of csr_addr; 0 for unowned addresses
- trap_req  out  1  interrupt trap request
- trap_cause  out  32  mcause value for the request
- trap_target  out  32  handler PC
- trap_ack  in  1  core accepts the request
- mret  in  1  core executed mret
- busy  out  1  interrupt in service

Behaviour:
- Owned CSRs:
  - mie 0x304: implemented bits 3, 7, 11, 16..16+NUM_IRQ-1; all other bits read 0.
  - mip 0x344:
    - Bit 3 (MSIP) is software read/write.
    - Bits 7 and 11 mirror timer_irq and ext_irq.
    - Platform bits are read-only pending flags.
  - mtvec 0x305: mode field is WARL; writes of 2 or 3 store 0.
  - irq_edge 0x7C0: bit k=1 makes source k edge-triggered, 0 makes it level.
- Platform pending flags:
  - Level sources: pend[k] = synchronised irq_in[k].
  - Edge sources:
    - The synchronised rising edge sets a sticky pend[k].
    - Acceptance of source k clears it.
    - If a set and the clear land in the same cycle, set wins.
- Latency: for SYNC_STAGES=2, irq_in rising before edge n gives pending at edge n+2 and trap_req high after edge n+3, assuming enabled and IDLE.
- Arbitration: the eligible set is mip & mie, gated by mstatus_mie. Fixed priority, highest first:
  - MEI (11)
  - MSI (3)
  - MTI (7)
  - platform 16, 17, … ascending, lower index wins.
- Cause: trap_cause = {1'b1, 26'b0, code[4:0]}.
- Target:
  - mtvec[1:0]==1 (vectored): {mtvec[31:2],2'b0} + (code<<2).
  - Otherwise: {mtvec[31:2],2'b0}.
  - The mtvec value is sampled when the request is latched.
- FSM (registered outputs):
  - IDLE:
    - If an eligible source exists, latch cause and target, set trap_req=1 and go to REQ.
    - Otherwise trap_req=0 and busy=0.
  - REQ:
    - Hold trap_req, trap_cause and trap_target stable until trap_ack, even if the source drops or mie/mstatus_mie change (the request is committed).
    - On trap_ack: set trap_req=0 and busy=1, clear the edge pending bit of the taken source, go to SERVICE.
    - trap_ack in the same cycle the request is first raised counts as acceptance.
  - SERVICE:
    - No new request.
    - On mret: set busy=0 and go to IDLE. The earliest next trap_req is the cycle after IDLE is re-entered (one-cycle gap).
  - mret outside SERVICE is ignored. trap_ack outside REQ is ignored.
- CSR write while in REQ takes effect but does not alter the latched cause or target.
- Reset, asynchronous at any time, including mid-REQ:
  - FSM goes to IDLE.
  - trap_req=0, busy=0, trap_cause=0, trap_target=0.
  - mie=0, MSIP=0, pend=0, irq_edge=0, mtvec=TVEC_RESET.
  - Synchronisers cleared.

Optional Feature:
- Macro: RISCV_IRQ_PRIORITY_EN.
- When defined:
  - CSRs 0x7C1 (sources 0–7) and 0x7C2 (sources 8–15) hold a 3-bit priority per source in 4-bit fields; bit 3 of each field reads 0.
  - Among platform sources, the higher priority wins; ties go to the lower index.
  - Priority 0 means never taken, but the source still shows in mip.
  - MEI, MSI and MTI still outrank all platform sources.
  - Reset priority is 1 for every source.
- When undefined: fixed ascending-index order; 0x7C1/0x7C2 read 0 and writes are ignored.

Test Plan:
- Reset → trap_req=0, busy=0; mtvec reads 0x00000004; mie/mip read 0x00000000.
- Edge source 2 configured, mie=0x00040000, mtvec=0x00008001, mstatus_mie=1; one-cycle pulse on irq_in[2] → trap_req after 3 edges, cause=0x80000012, target=0x00008048; trap_ack → mip bit 18 clears, busy=1.
- ext_irq and level irq_in[0] high together → cause 0x8000000B first; after ack and mret, next request has cause 0x80000010, with trap_req low for at least one cycle between.
- mstatus_mie=0 with MTI enabled and pending → no request; raise mstatus_mie → trap_req next cycle, cause 0x80000007, target=mtvec base in direct mode.
- Level source 1 deasserts while in REQ → trap_req and cause 0x80000011 held until trap_ack; reset asserted mid-REQ → all outputs 0 immediately.
- With RISCV_IRQ_PRIORITY_EN: priority of source 1=5 and source 4=6, both pending → cause 0x80000014; source 4 priority=0 → cause 0x80000011.
